pulse_window_accumulator: RTL

PULSE_WINDOW_ACCUMULATOR -- requirements
Module: pulse_window_accumulator

---
 rtl/pulse_window_accumulator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pulse_window_accumulator.sv
// Triggered window integrator: after a programmable delay, sums a programmable number of
// signed ADC samples and presents the result on a single-entry valid/ready output register.
module pulse_window_accumulator #(
    parameter int unsigned DATA_WIDTH   = 14,
    parameter int unsigned WINDOW_WIDTH = 8,
    parameter int unsigned DELAY_WIDTH  = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        pulse_in,
    input  logic [DELAY_WIDTH-1:0]                      delay,
    input  logic [WINDOW_WIDTH-1:0]                     window,
    input  logic signed [DATA_WIDTH-1:0]                adc_data,
    input  logic                                        clear_flags,
    output logic signed [DATA_WIDTH+WINDOW_WIDTH-1:0]   m_tdata,
    output logic                                        m_tvalid,
    input  logic                                        m_tready,
    output logic                                        busy,
    output logic                                        overflow,
    output logic                                        trig_missed
);

    localparam int unsigned SUM_WIDTH = DATA_WIDTH + WINDOW_WIDTH;
    localparam int unsigned CNT_WIDTH = (DELAY_WIDTH > WINDOW_WIDTH) ? DELAY_WIDTH : WINDOW_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StAccum
    } state_e;

    state_e                       state_q, state_d;
    logic                         pulse_dly_q;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [WINDOW_WIDTH-1:0]      window_q, window_d;
    logic signed [SUM_WIDTH-1:0]  acc_q, acc_d;
    logic signed [SUM_WIDTH-1:0]  tdata_q, tdata_d;
    logic                         tvalid_q, tvalid_d;
    logic                         overflow_q, overflow_d;
    logic                         missed_q, missed_d;

    logic                         trigger;
    logic                         out_free;
    logic                         last_cnt;
    logic signed [SUM_WIDTH-1:0]  sample_ext;
    logic signed [SUM_WIDTH-1:0]  acc_sum;

    assign trigger    = pulse_in & ~pulse_dly_q;
    assign out_free   = ~tvalid_q | m_tready;
    assign last_cnt   = (cnt_q == CNT_WIDTH'(1));
    assign sample_ext = {{WINDOW_WIDTH{adc_data[DATA_WIDTH-1]}}, adc_data};
    // SUM_WIDTH leaves room for 2^WINDOW_WIDTH-1 full-scale samples, so no wrap is possible.
    assign acc_sum    = acc_q + sample_ext;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        window_d   = window_q;
        acc_d      = acc_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        overflow_d = overflow_q;
        missed_d   = missed_q;

        if (clear_flags) begin
            overflow_d = 1'b0;
            missed_d   = 1'b0;
        end

        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (trigger && (window != '0)) begin
                    window_d = window;
                    if (delay == '0) begin
                        state_d = StAccum;
                        cnt_d   = CNT_WIDTH'(window);
                        acc_d   = '0;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = CNT_WIDTH'(delay);
                    end
                end
            end
            StDelay: begin
                if (last_cnt) begin
                    state_d = StAccum;
                    cnt_d   = CNT_WIDTH'(window_q);
                    acc_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StAccum: begin
                acc_d = acc_sum;
                if (last_cnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (out_free) begin
                        tdata_d  = acc_sum;
                        tvalid_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (trigger && (state_q != StIdle)) begin
            missed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // pulse_dly_q resets high so a pulse already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_dly_q <= 1'b1;
            cnt_q       <= '0;
            window_q    <= '0;
            acc_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            pulse_dly_q <= pulse_in;
            cnt_q       <= cnt_d;
            window_q    <= window_d;
            acc_q       <= acc_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            overflow_q  <= overflow_d;
            missed_q    <= missed_d;
        end
    end

    assign m_tdata     = tdata_q;
    assign m_tvalid    = tvalid_q;
    assign busy        = (state_q != StIdle);
    assign overflow    = overflow_q;
    assign trig_missed = missed_q;

endmodule
